// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and beat type for the N-way registered selector
// Purpose: default slot geometry, the out-of-range default value and the
//          buffer-entry beat struct used by mux_n_sel / mux_n_pipe and their users.
package mux_pkg;

   localparam int MUX_DEFAULT_WIDTH = 32;
   localparam int MUX_DEFAULT_N_IN  = 3;

   localparam logic [MUX_DEFAULT_WIDTH-1:0] MUX_DEFAULT_VAL = '0;

   // Buffer entry at the default data width; parametrised instances build the
   // same {data, sel_err} layout at their own WIDTH.
   typedef struct packed {
      logic [MUX_DEFAULT_WIDTH-1:0] data;
      logic                         sel_err;
   } mux_beat_t;

endpackage

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - combinational N_IN:1 selector with out-of-range detection
// Purpose: picks slot[sel]; drives DEFAULT_VAL and err=1 when sel >= N_IN.
// Ports:
//   in_data  N_IN*WIDTH  flattened slots, slot k = in_data[k*WIDTH +: WIDTH]
//   sel      SEL_W       slot index
//   data     WIDTH       selected value
//   err      1           sel was out of range
module mux_n_sel
   import mux_pkg::*;
#(
   parameter int               WIDTH       = MUX_DEFAULT_WIDTH,
   parameter int               N_IN        = MUX_DEFAULT_N_IN,
   parameter int               SEL_W       = $clog2(N_IN),
   parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(MUX_DEFAULT_VAL)
)(
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      data,
   output logic                  err
);

   // Any sel value that matches no slot falls through to the defaults.
   always_comb begin
      data = DEFAULT_VAL;
      err  = 1'b1;
      for (int k = 0; k < N_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            data = in_data[k*WIDTH +: WIDTH];
            err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - registered N-way selector with valid/ready handshake and error counter
// Purpose: captures the mux_n_sel result on accept and presents it one cycle later.
// Build option: MUX_N_PIPE_SKID_EN adds a skid slot so in_ready is a flop output.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_data/sel/in_valid    upstream beat; in_ready back to upstream
//   out_data/out_sel_err    registered selection and its out-of-range flag
//   out_valid/out_ready     downstream handshake
//   err_count/err_clear     saturating count of accepted out-of-range beats, clear
module mux_n_pipe
   import mux_pkg::*;
#(
   parameter int               WIDTH       = MUX_DEFAULT_WIDTH,
   parameter int               N_IN        = MUX_DEFAULT_N_IN,
   parameter int               SEL_W       = $clog2(N_IN),
   parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(MUX_DEFAULT_VAL),
   parameter int               ERR_CNT_W   = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sel_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ERR_CNT_W-1:0]  err_count,
   input  logic                  err_clear
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sel_err;
   } beat_t;

   logic [WIDTH-1:0]     sel_data;
   logic                 sel_err;
   beat_t                sel_beat;
   beat_t                out_q;
   logic                 out_valid_q;
   logic                 accept;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   mux_n_sel #(
      .WIDTH       (WIDTH),
      .N_IN        (N_IN),
      .SEL_W       (SEL_W),
      .DEFAULT_VAL (DEFAULT_VAL)
   ) u_sel (
      .in_data (in_data),
      .sel     (sel),
      .data    (sel_data),
      .err     (sel_err)
   );

   assign sel_beat    = '{data: sel_data, sel_err: sel_err};
   assign accept      = in_valid && in_ready;
   assign out_data    = out_q.data;
   assign out_sel_err = out_q.sel_err;
   assign out_valid   = out_valid_q;

`ifdef MUX_N_PIPE_SKID_EN
   beat_t skid_q, skid_nx, out_nx;
   logic  skid_valid_q, skid_valid_nx, out_valid_nx, in_ready_q;

   // The skid slot is only ever filled while the output register is stalled,
   // and upstream is held off while it is full, so accept never meets a full slot.
   always_comb begin
      out_nx        = out_q;
      out_valid_nx  = out_valid_q;
      skid_nx       = skid_q;
      skid_valid_nx = skid_valid_q;
      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_nx        = skid_q;
            out_valid_nx  = 1'b1;
            skid_valid_nx = 1'b0;
         end else if (accept) begin
            out_nx       = sel_beat;
            out_valid_nx = 1'b1;
         end else begin
            out_valid_nx = 1'b0;
         end
      end else if (accept) begin
         skid_nx       = sel_beat;
         skid_valid_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         out_q        <= out_nx;
         out_valid_q  <= out_valid_nx;
         skid_q       <= skid_nx;
         skid_valid_q <= skid_valid_nx;
         in_ready_q   <= !skid_valid_nx;
      end
   end

   assign in_ready = in_ready_q;
`else
   assign in_ready = !reset && (!out_valid_q || out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_q       <= sel_beat;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   // Clear wins over a same-cycle increment; all-ones is sticky until cleared.
   always_ff @(posedge clk) begin
      if (reset || err_clear) begin
         err_cnt_q <= '0;
      end else if (accept && sel_beat.sel_err && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign err_count = err_cnt_q;

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

- Parametrised N-way, WIDTH-bit registered selector for the datapath.
- Replaces fixed 3-input 32-bit combinational selectors wherever the selected value crosses a pipeline boundary.
- Adds a valid/ready handshake with backpressure, out-of-range-select detection and a saturating error counter.
- With default parameters, each accepted beat produces the same value as the existing 3:1 selector, one cycle later.

## Interface
Parameters:
- WIDTH, 32, data width per input slot
- N_IN, 3, number of input slots (≥2)
- SEL_W, $clog2(N_IN), select width
- DEFAULT_VAL, 0, value driven for out-of-range select
- ERR_CNT_W, 16, error counter width

Ports (one clock `clk`; `reset` is synchronous, active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_data  input  N_IN*WIDTH  flattened slots; slot k = in_data[k*WIDTH +: WIDTH]
- sel  input  SEL_W  slot index
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept beat
- out_data  output  WIDTH  selected value
- out_sel_err  output  1  beat was produced from an out-of-range sel
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts beat
- err_count  output  ERR_CNT_W  saturating count of accepted out-of-range beats
- err_clear  input  1  synchronous clear of err_count

## Operation
- Accept: in_valid && in_ready at a rising edge.
- On accept, the combinational selection is captured together with its error flag:
  - data = slot[sel] if sel < N_IN, else DEFAULT_VAL.
  - err = (sel ≥ N_IN).
- Output transfer: out_valid && out_ready. out_data and out_sel_err are stable while out_valid && !out_ready.
- err_count:
  - +1 per accepted beat with err = 1; saturates at all-ones, no wrap.
  - err_clear has priority over a same-cycle increment and yields 0.
- Reset, synchronous: out_valid=0, out_data=0, out_sel_err=0, err_count=0, all internal valid bits 0. in_ready=0 while reset is high.
- Reset mid-operation drops any held beat; the beat is not delivered.
- No internal FSM beyond the buffer occupancy (EMPTY / ONE / TWO in the skid variant).

## Timing
- Latency: accept at edge t gives out_valid=1 after edge t, i.e. 1 cycle.
- Throughput: 1 beat/cycle under continuous out_ready=1 in both configurations.
- Without skid, in_ready = !out_valid || out_ready (combinational path from out_ready).
- Simultaneous accept and output transfer in the same cycle:
  - the output register is replaced by the new beat;
  - out_valid stays 1;
  - nothing is lost or duplicated.
- in_data and sel are sampled only at the accept edge. Changes while in_ready=0 have no effect.

## Configuration
- MUX_N_PIPE_SKID_EN defined:
  - a 2-entry skid buffer is instantiated;
  - in_ready is a flop output equal to "skid slot empty", with no combinational path from out_ready;
  - when out_ready drops, one further beat is absorbed into the skid slot;
  - the skid slot drains first, preserving order.
- MUX_N_PIPE_SKID_EN undefined: a single output register, and in_ready is combinational as in Timing.
- Beat order, latency and reset values are identical in both modes.

## Structure
- Shared package `mux_pkg`:
  - default WIDTH / N_IN constants;
  - DEFAULT_VAL;
  - beat struct {data, sel_err} for the buffer entries.
- Sub-module `mux_n_sel`: purely combinational N_IN:1 selector with out-of-range detection (outputs data, err). It is reused standalone where no register stage is wanted.
- `mux_n_pipe` contains the handshake, the buffer(s) and err_count.

## Test plan
1. Defaults, sel=2, slot2=32'hDEAD_BEEF, in_valid=1, out_ready=1 → next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel_err=0.
2. sel=3 (out of range, N_IN=3) → out_data=0, out_sel_err=1, err_count 0→1; err_clear the following cycle → err_count=0.
3. Stream sel=0,1,2,0 with out_ready low for 3 cycles mid-stream:
   - output order 0,1,2,0 with no loss or duplication;
   - out_data held stable while stalled;
   - skid build: exactly one extra beat absorbed after out_ready falls.
4. Continuous in_valid/out_ready=1 for 16 beats → 16 beats in 17 cycles, in_ready never deasserts.
5. ERR_CNT_W=2, 5 out-of-range beats → err_count saturates at 3; err_clear together with an error beat → 0.
6. reset asserted while out_valid=1 and stalled → next cycle out_valid=0, err_count=0, in_ready=0 during reset and 1 after release.
